// File: rtl/shift_pkg.sv
// Shared types and the one-bit step function for the sequential shifter/rotator.
package shift_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        ROL = 3'd0,
        ROR = 3'd1,
        SLL = 3'd2,
        SRL = 3'd3,
        SRA = 3'd4
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The operand sits in the low 'width' bits of a MAX_W container.
    // The return value is {carry, next_work}. Codes 5-7 pass through with carry 0.
    function automatic logic [MAX_W:0] step1(input logic [MAX_W-1:0] work,
                                             input logic [2:0]       mode,
                                             input int unsigned      width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] top;
        logic [MAX_W-1:0] nxt;
        logic             msb;
        logic             lsb;
        logic             c;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        top  = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        msb  = |(work & top);
        lsb  = work[0];
        case (mode)
            ROL: begin nxt = ((work << 1) | {{(MAX_W-1){1'b0}}, msb}) & mask; c = msb; end
            ROR: begin nxt = (work >> 1) | (lsb ? top : '0);                   c = lsb; end
            SLL: begin nxt = (work << 1) & mask;                               c = msb; end
            SRL: begin nxt = work >> 1;                                        c = lsb; end
            SRA: begin nxt = (work >> 1) | (msb ? top : '0);                   c = lsb; end
            default: begin nxt = work;                                         c = 1'b0; end
        endcase
        return {c, nxt};
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter/rotator, WIDTH bits wide.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    logic [MAX_W-1:0] din_x;
    logic [MAX_W:0]   r;

    always_comb begin
        din_x            = '0;
        din_x[WIDTH-1:0] = din;
        r                = step1(din_x, mode, WIDTH);
    end

    assign dout  = r[WIDTH-1:0];
    assign carry = r[MAX_W];

    generate
        if (WIDTH < MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^r[MAX_W-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/shift_rotate_seq.sv
// Sequential rotate/shift unit: one bit position per clock, valid/ready on both sides.
// state | meaning
// IDLE  | in_ready high, waiting for a request
// SHIFT | stepping work one position per clock until cnt runs out
// HOLD  | out_valid high, result held until out_ready
module shift_rotate_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] shl,
    output logic             carry,
    output logic             zero
);

    localparam logic [AMT_W-1:0] ONE = AMT_W'(1);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [2:0]       mode_q;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_in;
    logic [WIDTH-1:0] step_out;
    logic [2:0]       step_mode;
    logic             step_c;

    assign in_ready = (state == IDLE);

    // The first step is taken on the acceptance edge so latency equals amt.
    always_comb begin
        step_in   = work;
        step_mode = mode_q;
        if (state == IDLE) begin
            step_in   = b;
            step_mode = mode;
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .din   (step_in),
        .mode  (step_mode),
        .dout  (step_out),
        .carry (step_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            mode_q    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            shl       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q <= mode;
                        if (amt == '0 || mode > SRA) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            shl       <= b;
                            carry     <= 1'b0;
                            zero      <= (b == '0);
                        end else if (amt == ONE) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            shl       <= step_out;
                            carry     <= step_c;
                            zero      <= (step_out == '0);
                        end else begin
                            state <= SHIFT;
                            work  <= step_out;
                            cnt   <= amt - ONE;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_out;
                    cnt  <= cnt - ONE;
                    if (cnt == ONE) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        shl       <= step_out;
                        carry     <= step_c;
                        zero      <= (step_out == '0);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Directed and model-checked bench for shift_rotate_seq at WIDTH=8 and WIDTH=16.
module tb_shift_rotate_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, carry, zero;
    logic [7:0]  b, shl;
    logic [2:0]  mode, amt;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_carry, w_zero;
    logic [15:0] w_b, w_shl;
    logic [2:0]  w_mode;
    logic [3:0]  w_amt;

    int n_checks;
    int n_fail;

    shift_rotate_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .b(b), .mode(mode), .amt(amt), .out_valid(out_valid), .out_ready(out_ready),
        .shl(shl), .carry(carry), .zero(zero)
    );

    shift_rotate_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .b(w_b), .mode(w_mode), .amt(w_amt), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .shl(w_shl), .carry(w_carry), .zero(w_zero)
    );

    always #5 clk = ~clk;

    // Closed-form reference: {carry, result} for a k-position operation on a w-bit operand.
    function automatic logic [16:0] model(input logic [15:0] bv, input int mv, input int k, input int w);
        logic [31:0] mask, bb, res;
        logic        c;
        mask = (32'h1 << w) - 32'h1;
        bb   = {16'h0, bv} & mask;
        if (mv > 4 || k == 0) return {1'b0, bb[15:0]};
        case (mv)
            0: begin res = ((bb << k) | (bb >> (w - k))) & mask; c = bb[w-k]; end
            1: begin res = ((bb >> k) | (bb << (w - k))) & mask; c = bb[k-1]; end
            2: begin res = (bb << k) & mask; c = bb[w-k]; end
            3: begin res = bb >> k; c = bb[k-1]; end
            default: begin
                res = bb >> k;
                if (bb[w-1]) res = res | (mask & ~(mask >> k));
                c = bb[k-1];
            end
        endcase
        return {c, res[15:0]};
    endfunction

    task automatic issue8(input logic [7:0] bv, input logic [2:0] mv, input logic [2:0] av, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1; b = bv; mode = mv; amt = av;
        @(posedge clk); #1;
        in_valid = 1'b0; b = 8'($urandom); mode = 3'($urandom); amt = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release8();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] bv, input logic [2:0] mv, input logic [3:0] av, output int lat);
        int n;
        n = 0;
        while (!w_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        w_in_valid = 1'b1; w_b = bv; w_mode = mv; w_amt = av;
        @(posedge clk); #1;
        w_in_valid = 1'b0; w_b = 16'($urandom); w_mode = 3'($urandom); w_amt = 4'($urandom);
        lat = 1;
        while (!w_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (shl !== 8'h00) begin n_fail++; $display("FAIL reset_shl: got %h want 00", shl); end
        n_checks++; if (carry !== 1'b0 || zero !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got c=%b z=%b want 0 0", carry, zero); end
        n_checks++; if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_shl !== 16'h0) begin
            n_fail++; $display("FAIL reset_w16: got rdy=%b vld=%b shl=%h want 1 0 0000", w_in_ready, w_out_valid, w_shl); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rol();
        int lat;
        issue8(8'b1000_0001, 3'd0, 3'd1, lat);
        n_checks++; if (shl !== 8'b0000_0011 || carry !== 1'b1 || zero !== 1'b0 || lat != 1) begin
            n_fail++; $display("FAIL rol_81_1: got shl=%h c=%b z=%b lat=%0d want 03 1 0 1", shl, carry, zero, lat); end
        release8();
    endtask

    task automatic test_sra();
        int lat;
        issue8(8'hA4, 3'd4, 3'd3, lat);
        n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sra_latency: got %0d want 3", lat); end
        n_checks++; if (shl !== 8'hF4 || carry !== 1'b1 || zero !== 1'b0) begin
            n_fail++; $display("FAIL sra_a4_3: got shl=%h c=%b z=%b want f4 1 0", shl, carry, zero); end
        release8();
    endtask

    task automatic test_sll();
        int lat;
        issue8(8'h80, 3'd2, 3'd1, lat);
        n_checks++; if (shl !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            n_fail++; $display("FAIL sll_80_1: got shl=%h c=%b z=%b want 00 1 1", shl, carry, zero); end
        release8();
        issue8(8'h5A, 3'd2, 3'd0, lat);
        n_checks++; if (shl !== 8'h5A || carry !== 1'b0 || zero !== 1'b0 || lat != 1) begin
            n_fail++; $display("FAIL sll_amt0: got shl=%h c=%b z=%b lat=%0d want 5a 0 0 1", shl, carry, zero, lat); end
        release8();
    endtask

    task automatic test_illegal();
        int lat;
        for (int m = 5; m <= 7; m++) begin
            issue8(8'h3C, 3'(m), 3'd3, lat);
            n_checks++; if (shl !== 8'h3C || carry !== 1'b0 || lat != 1) begin
                n_fail++; $display("FAIL illegal_mode%0d: got shl=%h c=%b lat=%0d want 3c 0 1", m, shl, carry, lat); end
            release8();
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        issue8(8'hF0, 3'd3, 3'd2, lat);
        n_checks++; if (shl !== 8'h3C || carry !== 1'b0 || lat != 2) begin
            n_fail++; $display("FAIL srl_f0_2: got shl=%h c=%b lat=%0d want 3c 0 2", shl, carry, lat); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; b = 8'(i * 37 + 1); mode = 3'd0; amt = 3'd1;
            @(posedge clk); #1;
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || shl !== 8'h3C) begin
                n_fail++; $display("FAIL bp_hold_%0d: got rdy=%b vld=%b shl=%h want 0 1 3c", i, in_ready, out_valid, shl); end
        end
        b = 8'h77; mode = 3'd0; amt = 3'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || shl !== 8'h3C) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b vld=%b shl=%h want 1 0 3c", in_ready, out_valid, shl); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || shl !== 8'h77 || carry !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back: got vld=%b shl=%h c=%b want 1 77 0", out_valid, shl, carry); end
        release8();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic seen;
        in_valid = 1'b1; b = 8'h01; mode = 3'd1; amt = 3'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || shl !== 8'h00 || carry !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_op: got vld=%b rdy=%b shl=%h c=%b want 0 1 00 0", out_valid, in_ready, shl, carry); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_result: got out_valid seen=%b want 0", seen); end
        issue8(8'h01, 3'd1, 3'd4, lat);
        n_checks++; if (shl !== 8'h10 || carry !== 1'b0 || lat != 4) begin
            n_fail++; $display("FAIL ror_after_reset: got shl=%h c=%b lat=%0d want 10 0 4", shl, carry, lat); end
        release8();
    endtask

    task automatic test_rotate_equiv();
        int lat;
        logic [7:0]  r_left;
        logic [16:0] exp;
        for (int k = 1; k < 8; k++) begin
            exp = model(16'h00B5, 0, k, 8);
            issue8(8'hB5, 3'd0, 3'(k), lat);
            r_left = shl;
            release8();
            issue8(8'hB5, 3'd1, 3'(8 - k), lat);
            n_checks++; if (shl !== r_left || r_left !== exp[7:0]) begin
                n_fail++; $display("FAIL rol_ror_equiv k=%0d: got rol=%h ror=%h want %h", k, r_left, shl, exp[7:0]); end
            release8();
        end
    endtask

    task automatic test_regression();
        int          lat, mv, av, exp_lat;
        logic [15:0] bv;
        logic [16:0] exp;
        for (int i = 0; i < 600; i++) begin
            bv = 16'($urandom_range(0, 255)); mv = $urandom_range(0, 7); av = $urandom_range(0, 7);
            exp = model(bv, mv, av, 8);
            exp_lat = (av == 0 || mv > 4) ? 1 : av;
            issue8(bv[7:0], 3'(mv), 3'(av), lat);
            n_checks++;
            if (shl !== exp[7:0] || carry !== exp[16] || zero !== (exp[7:0] == 8'h00) || lat != exp_lat) begin
                n_fail++;
                $display("FAIL regress8 op%0d b=%h m=%0d a=%0d: got shl=%h c=%b z=%b lat=%0d want %h %b lat=%0d",
                         i, bv[7:0], mv, av, shl, carry, zero, lat, exp[7:0], exp[16], exp_lat);
            end
            release8();
        end
        for (int i = 0; i < 400; i++) begin
            bv = 16'($urandom); mv = $urandom_range(0, 7); av = $urandom_range(0, 15);
            exp = model(bv, mv, av, 16);
            exp_lat = (av == 0 || mv > 4) ? 1 : av;
            issue16(bv, 3'(mv), 4'(av), lat);
            n_checks++;
            if (w_shl !== exp[15:0] || w_carry !== exp[16] || w_zero !== (exp[15:0] == 16'h0) || lat != exp_lat) begin
                n_fail++;
                $display("FAIL regress16 op%0d b=%h m=%0d a=%0d: got shl=%h c=%b z=%b lat=%0d want %h %b lat=%0d",
                         i, bv, mv, av, w_shl, w_carry, w_zero, lat, exp[15:0], exp[16], exp_lat);
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; b = '0; mode = '0; amt = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_b = '0; w_mode = '0; w_amt = '0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_rol();
        test_sra();
        test_sll();
        test_illegal();
        test_back_pressure();
        test_reset_mid_op();
        test_rotate_equiv();
        test_regression();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
